sisa_bist_ctrl: RTL and testbench

Sequencing controller for a single-input signature analyzer (SISA) in the BIST response path. On `start` it loads a seed, compacts a serial response stream of programmable length, and compares the final signature against a golden value. It then reports pass/fail and holds the result for the test-access logic. It owns the signature register, implemented as a small sub-module, and sits between the circuit-under-test response tap and the BIST status registers.

---
 rtl/sisa_bist_pkg.sv | 23 ++
 rtl/sisa_sig_reg.sv | 54 +++++
 rtl/sisa_bist_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_sisa_bist_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sisa_bist_pkg.sv
// Shared types and default widths for the SISA BIST controller.
//   sisa_bist_state_t : controller state encoding (IDLE, LOAD, RUN, CHECK, DONE)
//   SISA_*_DEF        : default parameter values for the controller
package sisa_bist_pkg;

  localparam int unsigned SISA_N_DEF     = 8;
  localparam int unsigned SISA_LEN_W_DEF = 16;
  localparam int unsigned SISA_TO_W_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } sisa_bist_state_t;

  // States in which a test is in progress.
  function automatic logic sisa_is_busy(input sisa_bist_state_t s);
    return (s == LOAD) || (s == RUN) || (s == CHECK);
  endfunction

endpackage

// File: rtl/sisa_sig_reg.sv
// Single-input signature register: N-bit shift register with polynomial
// feedback taken from bit 0 and the serial input folded into the MSB.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears the register)
//   load     : load seed (has priority over shift)
//   seed     : value loaded by load
//   shift    : compact one serial bit
//   sin      : serial input bit
//   poly     : feedback polynomial (MSB not used)
//   sig      : current signature
module sisa_sig_reg #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] seed,
  input  logic         shift,
  input  logic         sin,
  input  logic [N-1:0] poly,
  output logic [N-1:0] sig
);

  logic [N-1:0] r_sig;
  logic [N-1:0] w_sig_next;

  // The MSB feedback tap is implicit (s[0] always feeds the top bit).
  logic w_unused_poly_msb;
  assign w_unused_poly_msb = poly[N-1];

  // Next signature: load, compact one bit, or hold.
  always_comb begin
    w_sig_next = r_sig;
    if (load) begin
      w_sig_next = seed;
    end else if (shift) begin
      w_sig_next[N-1] = r_sig[0] ^ sin;
      for (int i = 0; i < int'(N) - 1; i++) begin
        w_sig_next[i] = (r_sig[0] & poly[i]) ^ r_sig[i+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig <= '0;
    end else begin
      r_sig <= w_sig_next;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/sisa_bist_ctrl.sv
// SISA BIST sequencing controller: on start, loads a seed, compacts a serial
// response stream of programmable length, compares against a golden
// signature and holds pass/fail until the next start or abort.
// Optional idle watchdog in RUN: define SISA_BIST_TIMEOUT_EN.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start, abort         : begin a test (IDLE/DONE only) / return to IDLE
//   poly, seed, golden   : polynomial, initial and expected signature
//   test_len             : number of response bits to compact
//   resp_valid, resp_bit : serial response stream
//   resp_ready           : response bits accepted (RUN only)
//   busy, done, pass     : status (pass meaningful while done)
//   timeout              : run ended by watchdog (0 without the macro)
//   signature            : current signature register
module sisa_bist_ctrl
  import sisa_bist_pkg::*;
#(
  parameter int unsigned N     = SISA_N_DEF,
  parameter int unsigned LEN_W = SISA_LEN_W_DEF,
  parameter int unsigned TO_W  = SISA_TO_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [N-1:0]     poly,
  input  logic [N-1:0]     seed,
  input  logic [N-1:0]     golden,
  input  logic [LEN_W-1:0] test_len,
  input  logic             resp_valid,
  input  logic             resp_bit,
  output logic             resp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [N-1:0]     signature
);

  sisa_bist_state_t r_state;
  sisa_bist_state_t w_next;

  logic [N-1:0]     r_poly;
  logic [N-1:0]     r_seed;
  logic [N-1:0]     r_golden;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] w_count_inc;

  logic r_resp_ready;
  logic r_busy;
  logic r_done;
  logic r_pass;

  logic w_start_acc;
  logic w_accept;
  logic w_last;
  logic w_to_hit;
  logic w_timed_out;
  logic w_sig_load;
  logic [N-1:0] w_sig;

  // Abort suppresses both start acceptance and bit acceptance so the
  // signature holds its value on an abort edge.
  assign w_start_acc = start && !abort && ((r_state == IDLE) || (r_state == DONE));
  assign w_accept    = (r_state == RUN) && resp_valid && !abort;
  assign w_count_inc = r_count + LEN_W'(1);
  assign w_last      = (w_count_inc == r_len);
  assign w_sig_load  = (r_state == LOAD) && !abort;

  // Next-state logic; abort overrides every transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD:    w_next = (r_len == '0) ? CHECK : RUN;
      RUN:     if ((w_accept && w_last) || w_to_hit) w_next = CHECK;
      CHECK:   w_next = DONE;
      DONE:    if (start) w_next = LOAD;
      default: w_next = IDLE;
    endcase
    if (abort) w_next = IDLE;
  end

  // State register and state-decoded outputs, registered from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_resp_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_resp_ready <= (w_next == RUN);
      r_busy       <= sisa_is_busy(w_next);
      r_done       <= (w_next == DONE);
    end
  end

  // Test configuration captured on start acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_poly   <= '0;
      r_seed   <= '0;
      r_golden <= '0;
      r_len    <= '0;
    end else if (w_start_acc) begin
      r_poly   <= poly;
      r_seed   <= seed;
      r_golden <= golden;
      r_len    <= test_len;
    end
  end

  // Accepted-bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (r_state == LOAD) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= w_count_inc;
    end
  end

  // Pass flag: evaluated in CHECK, forced low after a watchdog expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pass <= 1'b0;
    end else if (abort || w_start_acc) begin
      r_pass <= 1'b0;
    end else if (r_state == CHECK) begin
      r_pass <= (w_sig == r_golden) && !w_timed_out;
    end
  end

`ifdef SISA_BIST_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_inc;
  logic            r_timeout;

  assign w_to_inc = r_to_cnt + TO_W'(1);
  // Expire on the idle edge that would bring the counter to all-ones.
  assign w_to_hit = (r_state == RUN) && !w_accept && (w_to_inc == {TO_W{1'b1}});

  // Idle-cycle watchdog, restarted on RUN entry and on every accepted bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if ((r_state == LOAD) || w_accept) begin
      r_to_cnt <= '0;
    end else if (r_state == RUN) begin
      r_to_cnt <= w_to_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else if (abort || w_start_acc) begin
      r_timeout <= 1'b0;
    end else if (w_to_hit) begin
      r_timeout <= 1'b1;
    end
  end

  assign w_timed_out = r_timeout;
  assign timeout     = r_timeout;
`else
  localparam int unsigned UNUSED_TO_W = TO_W;
  assign w_to_hit    = 1'b0;
  assign w_timed_out = 1'b0;
  assign timeout     = 1'b0;
`endif

  sisa_sig_reg #(
    .N (N)
  ) u_sig_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (w_sig_load),
    .seed  (r_seed),
    .shift (w_accept),
    .sin   (resp_bit),
    .poly  (r_poly),
    .sig   (w_sig)
  );

  assign resp_ready = r_resp_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign signature  = w_sig;

endmodule

// File: tb/tb_sisa_bist_ctrl.sv
// Directed testbench for sisa_bist_ctrl (N=8, LEN_W=16, TO_W=4).
module tb_sisa_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  poly;
  logic [7:0]  seed;
  logic [7:0]  golden;
  logic [15:0] test_len;
  logic        resp_valid;
  logic        resp_bit;
  logic        resp_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [7:0]  signature;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sisa_bist_ctrl #(
    .N     (8),
    .LEN_W (16),
    .TO_W  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .poly       (poly),
    .seed       (seed),
    .golden     (golden),
    .test_len   (test_len),
    .resp_valid (resp_valid),
    .resp_bit   (resp_bit),
    .resp_ready (resp_ready),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .signature  (signature)
  );

  typedef struct {
    logic [7:0]  poly;
    logic [7:0]  seed;
    logic [7:0]  golden;
    logic [15:0] len;
    logic [15:0] bits;     // bits[j] is the j-th response bit
    int          gap_at;   // insert 5 idle cycles before bit gap_at (-1: none)
    logic [7:0]  exp_sig;
    logic        exp_pass;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [7:0] p, input logic [7:0] s,
                         input logic [7:0] g, input logic [15:0] l);
    poly = p; seed = s; golden = g; test_len = l;
  endtask

  // Runs one record from DONE or IDLE and checks latency, signature and pass.
  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] saved;
    set_cfg(v.poly, v.seed, v.golden, v.len);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk($sformatf("v%0d load busy", idx), busy, 1);
    chk($sformatf("v%0d load ready", idx), resp_ready, 0);
    chk($sformatf("v%0d pass cleared", idx), pass, 0);
    if (v.len == 0) begin
      tick();
      chk($sformatf("v%0d edge2 done", idx), done, 0);
      tick();
      chk($sformatf("v%0d edge3 done", idx), done, 1);
    end else begin
      tick();
      chk($sformatf("v%0d run ready", idx), resp_ready, 1);
      for (int j = 0; j < int'(v.len); j++) begin
        if (j == v.gap_at) begin
          resp_valid = 1'b0;
          saved = signature;
          repeat (5) tick();
          chk($sformatf("v%0d gap hold", idx), signature, saved);
          chk($sformatf("v%0d gap ready", idx), resp_ready, 1);
        end
        resp_valid = 1'b1;
        resp_bit   = v.bits[j];
        tick();
      end
      resp_valid = 1'b0;
      chk($sformatf("v%0d check done", idx), done, 0);
      tick();
      chk($sformatf("v%0d done", idx), done, 1);
    end
    chk($sformatf("v%0d signature", idx), signature, v.exp_sig);
    chk($sformatf("v%0d pass", idx), pass, v.exp_pass);
    chk($sformatf("v%0d idle busy", idx), busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           poly   seed   golden len     bits      gap exp    pass
    vecs[0] = '{8'h1D, 8'h00, 8'h00, 16'd10, 16'h0000, -1, 8'h00, 1'b1};
    vecs[1] = '{8'h1D, 8'h00, 8'h80, 16'd1,  16'h0001, -1, 8'h80, 1'b1};
    vecs[2] = '{8'h1D, 8'h00, 8'h40, 16'd2,  16'h0001, -1, 8'h40, 1'b1};
    vecs[3] = '{8'h1D, 8'h00, 8'h41, 16'd2,  16'h0001, -1, 8'h40, 1'b0};
    vecs[4] = '{8'h1D, 8'h01, 8'h9D, 16'd1,  16'h0000, -1, 8'h9D, 1'b1};
    vecs[5] = '{8'h1D, 8'h01, 8'h34, 16'd3,  16'h0006, -1, 8'h34, 1'b1};
    vecs[6] = '{8'h1D, 8'h01, 8'h34, 16'd3,  16'h0006,  2, 8'h34, 1'b1};
    vecs[7] = '{8'hFF, 8'h00, 8'h4D, 16'd8,  16'h004D, -1, 8'h4D, 1'b1};
    vecs[8] = '{8'h1D, 8'hA5, 8'hA5, 16'd0,  16'h0000, -1, 8'hA5, 1'b1};
    vecs[9] = '{8'h1D, 8'h3C, 8'h00, 16'd0,  16'h0000, -1, 8'h3C, 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    resp_valid = 1'b0; resp_bit = 1'b0;
    set_cfg(8'h00, 8'h00, 8'h00, 16'd0);
    repeat (2) tick();
    rst = 1'b0;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset pass", pass, 0);
    chk("reset ready", resp_ready, 0);
    chk("reset timeout", timeout, 0);
    chk("reset signature", signature, 0);

    // Response bits offered in IDLE are dropped.
    resp_valid = 1'b1; resp_bit = 1'b1;
    repeat (3) tick();
    resp_valid = 1'b0;
    chk("idle drop signature", signature, 0);
    chk("idle drop busy", busy, 0);

    for (int k = 0; k < NV; k++) run_vec(vecs[k], k);

    // start while in RUN is ignored; stream 0,1,1 from seed 01 still gives 34.
    set_cfg(8'h1D, 8'h01, 8'h34, 16'd3);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    resp_valid = 1'b1; resp_bit = 1'b0; tick();
    resp_valid = 1'b0;
    set_cfg(8'h00, 8'hFF, 8'h00, 16'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("start in run busy", busy, 1);
    chk("start in run ready", resp_ready, 1);
    chk("start in run signature", signature, 8'h9D);
    resp_valid = 1'b1; resp_bit = 1'b1; tick();
    resp_bit = 1'b1; tick();
    resp_valid = 1'b0;
    chk("start in run check", done, 0);
    tick();
    chk("start in run done", done, 1);
    chk("start in run sig", signature, 8'h34);
    chk("start in run pass", pass, 1);

    // abort in DONE clears pass and done.
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort done pass", pass, 0);
    chk("abort done done", done, 0);

    // abort in RUN: back to IDLE, signature holds despite a valid bit.
    set_cfg(8'h1D, 8'h01, 8'h00, 16'd3);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    resp_valid = 1'b1; resp_bit = 1'b0; tick();
    chk("abort pre sig", signature, 8'h9D);
    abort = 1'b1; resp_bit = 1'b1; tick();
    abort = 1'b0; resp_valid = 1'b0;
    chk("abort run busy", busy, 0);
    chk("abort run done", done, 0);
    chk("abort run pass", pass, 0);
    chk("abort run ready", resp_ready, 0);
    chk("abort run sig", signature, 8'h9D);

    // rst in RUN wins over simultaneous start and abort.
    set_cfg(8'h1D, 8'h01, 8'h00, 16'd3);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    resp_valid = 1'b1; resp_bit = 1'b0; tick();
    resp_valid = 1'b0;
    rst = 1'b1; start = 1'b1; abort = 1'b1; tick();
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    chk("rst run busy", busy, 0);
    chk("rst run done", done, 0);
    chk("rst run pass", pass, 0);
    chk("rst run ready", resp_ready, 0);
    chk("rst run sig", signature, 0);

    // Stall in RUN with no response bits.
    set_cfg(8'h1D, 8'h5A, 8'h5A, 16'd3);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("stall enter ready", resp_ready, 1);
`ifdef SISA_BIST_TIMEOUT_EN
    repeat (14) tick();
    chk("stall 14 ready", resp_ready, 1);
    chk("stall 14 timeout", timeout, 0);
    tick();
    chk("stall 15 timeout", timeout, 1);
    chk("stall 15 ready", resp_ready, 0);
    chk("stall 15 busy", busy, 1);
    tick();
    chk("timeout done", done, 1);
    chk("timeout pass", pass, 0);
    chk("timeout held", timeout, 1);
    set_cfg(8'h1D, 8'h5A, 8'h5A, 16'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("timeout cleared", timeout, 0);
    repeat (2) tick();
    chk("after timeout done", done, 1);
    chk("after timeout pass", pass, 1);
`else
    repeat (20) tick();
    chk("stall busy", busy, 1);
    chk("stall ready", resp_ready, 1);
    chk("stall timeout", timeout, 0);
    chk("stall sig", signature, 8'h5A);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("stall abort busy", busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
